// File: rtl/phase_meas_scheduler.sv
// phase_meas_scheduler
// Time-shares one phase detector between NUM_CH reference/feedback clock
// pairs. Each visit switches the external mux and pulses the detector
// reset. It then throws away SETTLE_SAMPLES detector samples and averages
// the next 2**AVG_LOG2 samples into one tagged result. Enabled channels are
// visited round-robin. A visit that does not collect its samples within
// TIMEOUT_CYC cycles reports a timeout instead of a phase.
//
// Optional build macro: PHASE_SCHED_MINMAX_EN adds res_min/res_max, which
// hold the smallest and largest averaged sample of each visit.
//
// Ports
//   clk_sample   in   sample clock (same clock as the detector)
//   rst          in   synchronous, active-high reset
//   enable       in   run scheduling; 0 aborts the current visit and idles
//   ch_mask      in   per-channel enable bits, sampled at each channel decision
//   pd_err       in   detector phase error (two's complement)
//   pd_valid     in   detector phase error strobe
//   pd_sel       out  clock-pair mux select
//   pd_rst       out  one-cycle detector reset pulse on every channel switch
//   busy         out  scheduler not idle
//   res_valid    out  one-cycle result strobe
//   res_ch       out  channel of the last result
//   res_phase    out  averaged phase error of the last result
//   res_timeout  out  last result was a timeout (res_phase is then 0)
//   res_min/max  out  (PHASE_SCHED_MINMAX_EN only) extreme samples of the visit
module phase_meas_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int PHASE_W        = 28,
  parameter int SETTLE_SAMPLES = 2,
  parameter int AVG_LOG2       = 2,
  parameter int TIMEOUT_CYC    = 1048576
) (
  input  logic                      clk_sample,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_mask,
  input  logic [PHASE_W-1:0]        pd_err,
  input  logic                      pd_valid,
  output logic [$clog2(NUM_CH)-1:0] pd_sel,
  output logic                      pd_rst,
  output logic                      busy,
  output logic                      res_valid,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [PHASE_W-1:0]        res_phase,
  output logic                      res_timeout
`ifdef PHASE_SCHED_MINMAX_EN
  ,
  output logic signed [PHASE_W-1:0] res_min,
  output logic signed [PHASE_W-1:0] res_max
`endif
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int DSC_W = $clog2(SETTLE_SAMPLES + 1);
  localparam int NCT_W = AVG_LOG2 + 1;
  localparam int SUM_W = PHASE_W + AVG_LOG2;

  localparam logic [DSC_W-1:0] DSC_LAST = DSC_W'(SETTLE_SAMPLES - 1);
  localparam logic [NCT_W-1:0] N_LAST   = NCT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SWITCH = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_ACCUM  = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  logic [2:0]                state_r;
  logic [2:0]                next_state_s;
  logic [SEL_W-1:0]          pd_sel_r;
  logic [SEL_W-1:0]          start_r;
  logic                      pd_rst_r;
  logic                      busy_r;
  logic                      res_valid_r;
  logic [SEL_W-1:0]          res_ch_r;
  logic [PHASE_W-1:0]        res_phase_r;
  logic                      res_timeout_r;
  logic [DSC_W-1:0]          dsc_r;
  logic [TMR_W-1:0]          tmr_r;
  logic [NCT_W-1:0]          nct_r;
  logic signed [SUM_W-1:0]   sum_r;

  logic [SEL_W-1:0]          next_start_s;
  logic [SEL_W-1:0]          dec_start_s;
  logic [SEL_W-1:0]          pick_s;
  logic                      go_s;
  logic                      done_s;
  logic                      tmo_s;
  logic signed [PHASE_W-1:0] sample_s;
  logic signed [SUM_W-1:0]   sum_next_s;

`ifdef PHASE_SCHED_MINMAX_EN
  logic signed [PHASE_W-1:0] min_r;
  logic signed [PHASE_W-1:0] max_r;
  logic signed [PHASE_W-1:0] min_next_s;
  logic signed [PHASE_W-1:0] max_next_s;
  logic signed [PHASE_W-1:0] res_min_r;
  logic signed [PHASE_W-1:0] res_max_r;
`endif

  // Lowest set mask bit at or above start; wraps to the lowest set bit overall.
  function automatic logic [SEL_W-1:0] pick_ch(input logic [NUM_CH-1:0] mask,
                                               input logic [SEL_W-1:0]  start);
    logic             found;
    logic [SEL_W-1:0] ch;
    found = 1'b0;
    ch    = {SEL_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i] && (i >= int'(start))) begin
        found = 1'b1;
        ch    = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && mask[i]) begin
        found = 1'b1;
        ch    = SEL_W'(i);
      end
    end
    return ch;
  endfunction

  // The decision taken in REPORT already uses the advanced search start, so
  // back-to-back visits need no extra IDLE cycle.
  assign next_start_s = (pd_sel_r == SEL_LAST) ? {SEL_W{1'b0}} : pd_sel_r + SEL_W'(1);
  assign dec_start_s  = (state_r == ST_REPORT) ? next_start_s : start_r;
  assign pick_s       = pick_ch(ch_mask, dec_start_s);
  assign sample_s     = signed'(pd_err);
  assign sum_next_s   = sum_r + SUM_W'(sample_s);

`ifdef PHASE_SCHED_MINMAX_EN
  // Running extremes including the current sample; the first sample seeds both.
  always_comb begin
    min_next_s = min_r;
    max_next_s = max_r;
    if ((nct_r == {NCT_W{1'b0}}) || (sample_s < min_r)) begin
      min_next_s = sample_s;
    end else begin
      min_next_s = min_r;
    end
    if ((nct_r == {NCT_W{1'b0}}) || (sample_s > max_r)) begin
      max_next_s = sample_s;
    end else begin
      max_next_s = max_r;
    end
  end
`endif

  // Next-state decision; dropping enable overrides everything.
  always_comb begin
    next_state_s = state_r;
    go_s         = 1'b0;
    done_s       = 1'b0;
    tmo_s        = 1'b0;
    if (!enable) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_REPORT: begin
          if (ch_mask != {NUM_CH{1'b0}}) begin
            next_state_s = ST_SWITCH;
            go_s         = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_SWITCH: begin
          next_state_s = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Timeout is checked first so the timer never runs past its limit.
          if (tmr_r == TMR_LAST) begin
            next_state_s = ST_REPORT;
            tmo_s        = 1'b1;
          end else if (pd_valid && (dsc_r == DSC_LAST)) begin
            next_state_s = ST_ACCUM;
          end else begin
            next_state_s = ST_SETTLE;
          end
        end
        ST_ACCUM: begin
          // A sample completing the average on the timeout cycle still counts.
          if (pd_valid && (nct_r == N_LAST)) begin
            next_state_s = ST_REPORT;
            done_s       = 1'b1;
          end else if (tmr_r == TMR_LAST) begin
            next_state_s = ST_REPORT;
            tmo_s        = 1'b1;
          end else begin
            next_state_s = ST_ACCUM;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk_sample) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pd_sel_r      <= {SEL_W{1'b0}};
      start_r       <= {SEL_W{1'b0}};
      pd_rst_r      <= 1'b0;
      busy_r        <= 1'b0;
      res_valid_r   <= 1'b0;
      res_ch_r      <= {SEL_W{1'b0}};
      res_phase_r   <= {PHASE_W{1'b0}};
      res_timeout_r <= 1'b0;
      dsc_r         <= {DSC_W{1'b0}};
      tmr_r         <= {TMR_W{1'b0}};
      nct_r         <= {NCT_W{1'b0}};
      sum_r         <= {SUM_W{1'b0}};
`ifdef PHASE_SCHED_MINMAX_EN
      min_r         <= {PHASE_W{1'b0}};
      max_r         <= {PHASE_W{1'b0}};
      res_min_r     <= {PHASE_W{1'b0}};
      res_max_r     <= {PHASE_W{1'b0}};
`endif
    end else begin
      state_r     <= next_state_s;
      busy_r      <= (next_state_s != ST_IDLE);
      pd_rst_r    <= go_s;
      res_valid_r <= done_s | tmo_s;
      if (go_s) begin
        pd_sel_r <= pick_s;
      end
      if (state_r == ST_REPORT) begin
        start_r <= next_start_s;
      end
      case (state_r)
        ST_SWITCH: begin
          dsc_r <= {DSC_W{1'b0}};
          tmr_r <= {TMR_W{1'b0}};
        end
        ST_SETTLE: begin
          tmr_r <= tmr_r + TMR_W'(1);
          if (pd_valid) begin
            dsc_r <= dsc_r + DSC_W'(1);
          end
          // Keep the accumulator cleared until averaging starts.
          sum_r <= {SUM_W{1'b0}};
          nct_r <= {NCT_W{1'b0}};
        end
        ST_ACCUM: begin
          tmr_r <= tmr_r + TMR_W'(1);
          if (pd_valid) begin
            sum_r <= sum_next_s;
            nct_r <= nct_r + NCT_W'(1);
`ifdef PHASE_SCHED_MINMAX_EN
            min_r <= min_next_s;
            max_r <= max_next_s;
`endif
          end
        end
        default: begin
        end
      endcase
      if (done_s) begin
        res_ch_r      <= pd_sel_r;
        res_phase_r   <= PHASE_W'(sum_next_s >>> AVG_LOG2);
        res_timeout_r <= 1'b0;
`ifdef PHASE_SCHED_MINMAX_EN
        res_min_r     <= min_next_s;
        res_max_r     <= max_next_s;
`endif
      end else if (tmo_s) begin
        res_ch_r      <= pd_sel_r;
        res_phase_r   <= {PHASE_W{1'b0}};
        res_timeout_r <= 1'b1;
`ifdef PHASE_SCHED_MINMAX_EN
        res_min_r     <= {PHASE_W{1'b0}};
        res_max_r     <= {PHASE_W{1'b0}};
`endif
      end
    end
  end

  assign pd_sel      = pd_sel_r;
  assign pd_rst      = pd_rst_r;
  assign busy        = busy_r;
  assign res_valid   = res_valid_r;
  assign res_ch      = res_ch_r;
  assign res_phase   = res_phase_r;
  assign res_timeout = res_timeout_r;
`ifdef PHASE_SCHED_MINMAX_EN
  assign res_min     = res_min_r;
  assign res_max     = res_max_r;
`endif

endmodule

// File: tb/tb_phase_meas_scheduler.sv
// Testbench for phase_meas_scheduler (NUM_CH=4, PHASE_W=28, SETTLE_SAMPLES=2,
// AVG_LOG2=2, TIMEOUT_CYC=64). A table of channel visits drives the round-robin,
// averaging and timeout paths. Hand-written sequences then cover abort/restart,
// mid-visit reset and the empty-mask idle case.
module tb_phase_meas_scheduler;
  localparam int PW = 28;
  localparam logic signed [PW-1:0] GARB = 28'sd99999;

  logic          clk_sample = 1'b0;
  logic          rst;
  logic          enable;
  logic [3:0]    ch_mask;
  logic [PW-1:0] pd_err;
  logic          pd_valid;
  logic [1:0]    pd_sel;
  logic          pd_rst;
  logic          busy;
  logic          res_valid;
  logic [1:0]    res_ch;
  logic [PW-1:0] res_phase;
  logic          res_timeout;
`ifdef PHASE_SCHED_MINMAX_EN
  logic signed [PW-1:0] res_min;
  logic signed [PW-1:0] res_max;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sample = ~clk_sample;

  phase_meas_scheduler #(
    .NUM_CH(4), .PHASE_W(PW), .SETTLE_SAMPLES(2), .AVG_LOG2(2), .TIMEOUT_CYC(64)
  ) dut (
    .clk_sample(clk_sample), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .pd_err(pd_err), .pd_valid(pd_valid), .pd_sel(pd_sel), .pd_rst(pd_rst),
    .busy(busy), .res_valid(res_valid), .res_ch(res_ch), .res_phase(res_phase),
    .res_timeout(res_timeout)
`ifdef PHASE_SCHED_MINMAX_EN
    , .res_min(res_min), .res_max(res_max)
`endif
  );

  typedef struct {
    logic [3:0]           mask;
    logic signed [PW-1:0] s0, s1, s2, s3;
    logic [1:0]           ch;
    logic signed [PW-1:0] phase, mn, mx;
    logic                 tmo;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [3:0] m, input int a, input int b, input int c,
                              input int d, input int ch, input int ph, input int mn,
                              input int mx, input logic tmo);
    vec_t v;
    v.mask = m;  v.s0 = PW'(a); v.s1 = PW'(b); v.s2 = PW'(c); v.s3 = PW'(d);
    v.ch = 2'(ch); v.phase = PW'(ph); v.mn = PW'(mn); v.mx = PW'(mx); v.tmo = tmo;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait (bounded) for the SWITCH cycle, feeding ignored samples meanwhile.
  task automatic wait_switch(input string tag, input logic [1:0] exp_ch);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk_sample);
      chk({tag, " res_valid before switch"}, res_valid, 0);
      seen = (pd_rst === 1'b1);
      pd_valid = 1'b1;
      pd_err   = GARB;
    end
    chk({tag, " pd_rst pulse seen"}, seen, 1);
    chk({tag, " pd_sel"}, pd_sel, exp_ch);
    chk({tag, " busy"}, busy, 1);
  endtask

  // One full channel visit; ends on the REPORT cycle after checking results.
  task automatic do_visit(input string tag, input vec_t v, input logic [3:0] mask_after);
    logic signed [PW-1:0] smp [4];
    smp[0] = v.s0; smp[1] = v.s1; smp[2] = v.s2; smp[3] = v.s3;
    wait_switch(tag, v.ch);
    if (v.tmo) begin
      for (int k = 1; k <= 65; k++) begin
        @(negedge clk_sample);
        if (k == 1)  chk({tag, " pd_rst one cycle"}, pd_rst, 0);
        if (k == 64) chk({tag, " no early timeout"}, res_valid, 0);
        if (k < 65) begin
          pd_valid = (k == 1 || k == 3 || k == 5 || k == 7);
          pd_err   = 28'sd500;
        end
      end
    end else begin
      @(negedge clk_sample);
      chk({tag, " pd_rst one cycle"}, pd_rst, 0);
      pd_valid = 1'b1; pd_err = GARB;
      @(negedge clk_sample);
      pd_valid = 1'b0;
      @(negedge clk_sample);
      pd_valid = 1'b1; pd_err = GARB;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk_sample);
        if (j == 3) chk({tag, " res_valid not early"}, res_valid, 0);
        pd_valid = 1'b1;
        pd_err   = smp[j];
        if (j < 3) begin
          @(negedge clk_sample);
          pd_valid = 1'b0;
        end
      end
      @(negedge clk_sample);
    end
    chk({tag, " res_valid"}, res_valid, 1);
    chk({tag, " res_ch"}, res_ch, v.ch);
    chk({tag, " res_phase"}, signed'(res_phase), v.phase);
    chk({tag, " res_timeout"}, res_timeout, v.tmo);
`ifdef PHASE_SCHED_MINMAX_EN
    chk({tag, " res_min"}, res_min, v.mn);
    chk({tag, " res_max"}, res_max, v.mx);
`endif
    ch_mask  = mask_after;
    pd_valid = 1'b1;
    pd_err   = GARB;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(4'b1111, 100, 100, 100, 100, 0, 100, 100, 100, 1'b0);
    vecs[1]  = mk(4'b1111, 100, 100, 100, 100, 1, 100, 100, 100, 1'b0);
    vecs[2]  = mk(4'b1111, 100, 100, 100, 100, 2, 100, 100, 100, 1'b0);
    vecs[3]  = mk(4'b1111, 100, 100, 100, 100, 3, 100, 100, 100, 1'b0);
    vecs[4]  = mk(4'b1111, 100, 100, 100, 100, 0, 100, 100, 100, 1'b0);
    vecs[5]  = mk(4'b0101, -2, -4, 6, 8, 2, 2, -4, 8, 1'b0);
    vecs[6]  = mk(4'b0101, -7, -7, -7, -6, 0, -7, -7, -6, 1'b0);
    vecs[7]  = mk(4'b0101, 134217727, 134217727, 134217727, 134217727, 2,
                  134217727, 134217727, 134217727, 1'b0);
    vecs[8]  = mk(4'b1000, -134217728, -134217728, -134217728, -134217728, 3,
                  -134217728, -134217728, -134217728, 1'b0);
    vecs[9]  = mk(4'b1000, 1, 2, 3, 5, 3, 2, 1, 5, 1'b0);
    vecs[10] = mk(4'b0010, -1, 0, 0, 0, 1, -1, -1, 0, 1'b0);
    vecs[11] = mk(4'b1111, 0, 0, 0, 0, 2, 0, 0, 0, 1'b1);
    vecs[12] = mk(4'b1111, 40, -40, 1000, -1000, 3, 0, -1000, 1000, 1'b0);

    rst = 1'b1; enable = 1'b0; ch_mask = 4'b0000; pd_err = '0; pd_valid = 1'b0;
    repeat (3) @(negedge clk_sample);
    chk("reset pd_sel", pd_sel, 0);
    chk("reset pd_rst", pd_rst, 0);
    chk("reset busy", busy, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_ch", res_ch, 0);
    chk("reset res_phase", signed'(res_phase), 0);
    chk("reset res_timeout", res_timeout, 0);

    // Enabled with an empty mask: must stay idle.
    rst = 1'b0; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sample);
      chk("empty mask busy", busy, 0);
      chk("empty mask pd_rst", pd_rst, 0);
    end
    ch_mask = vecs[0].mask;

    for (int i = 0; i < 13; i++) begin
      do_visit($sformatf("row%0d", i), vecs[i], (i < 12) ? vecs[i+1].mask : 4'b0001);
    end

    // Abort during ACCUM, then restart the same channel.
    wait_switch("abort", 2'd0);
    @(negedge clk_sample); pd_valid = 1'b1; pd_err = GARB;
    @(negedge clk_sample); pd_valid = 1'b1; pd_err = GARB;
    @(negedge clk_sample); pd_valid = 1'b1; pd_err = 28'sd50;
    @(negedge clk_sample);
    chk("abort busy before drop", busy, 1);
    enable = 1'b0; pd_valid = 1'b0;
    @(negedge clk_sample);
    chk("abort busy", busy, 0);
    chk("abort res_valid", res_valid, 0);
    chk("abort pd_sel holds", pd_sel, 0);
    ch_mask = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_sample);
      chk("disabled pd_rst", pd_rst, 0);
      chk("disabled res_valid", res_valid, 0);
    end
    enable = 1'b1;
    do_visit("restart", mk(4'b0011, 10, 20, 30, 40, 0, 25, 10, 40, 1'b0), 4'b0011);

    // Reset during SETTLE.
    wait_switch("midrst", 2'd1);
    @(negedge clk_sample); pd_valid = 1'b1; pd_err = GARB;
    @(negedge clk_sample);
    rst = 1'b1; pd_valid = 1'b0; ch_mask = 4'b1111;
    @(negedge clk_sample);
    chk("midrst pd_sel", pd_sel, 0);
    chk("midrst pd_rst", pd_rst, 0);
    chk("midrst busy", busy, 0);
    chk("midrst res_valid", res_valid, 0);
    chk("midrst res_ch", res_ch, 0);
    chk("midrst res_phase", signed'(res_phase), 0);
    chk("midrst res_timeout", res_timeout, 0);
    rst = 1'b0;
    do_visit("after rst", mk(4'b1111, 3, 3, 3, 3, 0, 3, 3, 3, 1'b0), 4'b0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sample);
      chk("final idle busy", busy, 0);
      chk("final idle pd_rst", pd_rst, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
